frame_rate_ctrl: RTL
====================

# frame_rate_ctrl

Parametrised animation-rate controller for the VGA pattern pipeline; the next generation of the speed controller. It takes N priority-encoded speed requests plus pause, resume and single-step controls from raw pins. It synchronises and edge-detects these controls, runs a small run/pause/step state machine, and emits a one-cycle `next_frame` advance pulse per enabled frame. It also provides a frame-stable `step_size` and a wrapping phase accumulator for the pattern generators.

## Interface
- `NUM_SPEEDS`, 6: number of speed request inputs; level range 1..NUM_SPEEDS.
- `STEP_W`, 12: width of `step_size`.
- `BASE_STEP`, 4: step increment per speed level.
- `PHASE_W`, 16: width of the phase accumulator.
- `SYNC_STAGES`, 2: synchroniser depth on pin inputs (≥2).

- `clk` in 1: system / pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `speed_req` in NUM_SPEEDS: bit i requests level i+1; raw pins.
- `pause` in 1: raw pin; rising edge requests pause.
- `resume` in 1: raw pin; rising edge requests run.
- `step` in 1: raw pin; rising edge requests one frame advance while paused.
- `frame_start` in 1: single-cycle pulse from timing generator; already synchronous, not synchronised.
- `next_frame` out 1: single-cycle advance pulse.
- `step_size` out STEP_W: step for the current frame.
- `speed_level` out $clog2(NUM_SPEEDS+1): latched speed level.
- `paused` out 1: high in PAUSED and STEP_PENDING.
- `phase` out PHASE_W: accumulated phase.

## Operation
- **Synchronisers:** `speed_req`, `pause`, `resume` and `step` each pass through SYNC_STAGES flops. For pause, resume and step, a rising edge is sync=1 with previous sync=0. That edge is a one-cycle internal event.
- **Speed encode:** the highest set synced `speed_req` bit wins. No bit set gives level 1.
  - The encoded level is latched into `speed_level` only on `frame_start`, so it is constant across a frame.
- **Step size:** `step_size` = `speed_level` × BASE_STEP, registered and updated together with `speed_level`. Saturate at 2^STEP_W−1 if the product overflows.
- **State machine (RUN, PAUSED, STEP_PENDING):**
  - RUN: `frame_start` → advance. A pause event → PAUSED. Resume and step events are ignored.
  - PAUSED: no advance. A resume event → RUN. A step event → STEP_PENDING.
  - STEP_PENDING: the next `frame_start` → advance, then → PAUSED. A resume event → RUN. Pause and step events are ignored.
- **Advance:** on the cycle after an enabling `frame_start`, `next_frame`=1 for exactly one cycle. In that same cycle, `phase` ← `phase` + `step_size`, using the `step_size` value latched by that `frame_start`. The phase wraps modulo 2^PHASE_W.
- **Simultaneous events:**
  - Pause and resume on the same cycle: pause wins. RUN→PAUSED; a PAUSED state stays PAUSED.
  - Resume and step on the same cycle in PAUSED: resume wins → RUN.
  - `frame_start` and pause on the same cycle in RUN: the frame still advances, and the state becomes PAUSED.
  - `frame_start` and step on the same cycle in PAUSED: no advance this frame. STEP_PENDING waits for the following `frame_start`.
- **Reset mid-operation:** all state is cleared immediately and asynchronously. A pending step is discarded. A `next_frame` in flight is dropped.

## Timing
- **Reset values:** state RUN; `next_frame`=0; `paused`=0; `speed_level`=1; `step_size`=BASE_STEP; `phase`=0; synchroniser flops 0.
  - Because the edge detectors reset to 0, a pin held high through reset produces no event after release.
- **Pin-to-state latency:** `paused` changes exactly SYNC_STAGES+1 rising edges after the first edge that samples the pin high (default 3).
- **Speed latency:** a `speed_req` change takes effect at the first `frame_start` at least SYNC_STAGES+1 cycles later.
- **frame_start → next_frame:** 1 cycle, registered. `phase` updates on the same edge that raises `next_frame`.
- **Event rate:** at most one `next_frame` per `frame_start`. `next_frame` never asserts on two consecutive cycles.

## Test plan
- **Reset and run:** release reset with `speed_req`=0, then apply 3 `frame_start` pulses → 3 `next_frame` pulses, each 1 cycle after its `frame_start`; `step_size`=4; `phase`=12.
- **Speed priority:** hold `speed_req`=6'b010100, then apply `frame_start` → `speed_level`=5, `step_size`=20. Clear `speed_req` and apply `frame_start` → level 1.
- **Pause and step:**
  - Pulse `pause`, then apply 4 `frame_start` → no `next_frame`; `paused`=1 after 3 cycles.
  - Pulse `step`, then apply 2 `frame_start` → exactly 1 `next_frame`; `paused` stays 1.
- **Resume and collisions:**
  - Raise `pause` and `resume` on the same cycle in RUN → PAUSED.
  - Then raise `resume` and `step` on the same cycle → RUN; the next `frame_start` advances.
- **Wrap and saturation:**
  - With PHASE_W=8 and level 6 (step 24), apply 11 frames → `phase` = 264 mod 256 = 8.
  - With STEP_W=4 and level 6 → `step_size`=15.
- **Async reset mid-step:** from STEP_PENDING, assert `rst_n`=0 between clock edges → outputs reach their reset values before the next edge; after release, `frame_start` advances in RUN.

Source files
------------

// File: rtl/frame_rate_ctrl.sv
// Animation-rate controller: synchronised pin controls, run/pause/step FSM,
// frame-stable step size and a wrapping phase accumulator.
module frame_rate_ctrl #(
  parameter int NUM_SPEEDS  = 6,
  parameter int STEP_W      = 12,
  parameter int BASE_STEP   = 4,
  parameter int PHASE_W     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_SPEEDS-1:0]           speed_req,
  input  logic                            pause,
  input  logic                            resume,
  input  logic                            step,
  input  logic                            frame_start,
  output logic                            next_frame,
  output logic [STEP_W-1:0]               step_size,
  output logic [$clog2(NUM_SPEEDS+1)-1:0] speed_level,
  output logic                            paused,
  output logic [PHASE_W-1:0]              phase
);

  localparam int LW = $clog2(NUM_SPEEDS + 1);
  localparam int SW = NUM_SPEEDS + 3;
  localparam logic [63:0] MAXS = (64'd1 << STEP_W) - 64'd1;

  typedef enum logic [1:0] {
    RUN,
    PAUSED,
    STEP_PEND
  } state_e;

  function automatic logic [STEP_W-1:0] sat_step(input logic [LW-1:0] lv);
    logic [63:0] p;
    p = 64'(lv) * 64'(BASE_STEP);
    if (p > MAXS) return STEP_W'(MAXS);
    return STEP_W'(p);
  endfunction

  // {step, resume, pause, speed_req} share one synchroniser chain
  logic [SW-1:0]      sync_q [SYNC_STAGES];
  logic [SW-1:0]      synced;
  logic [2:0]         ctl_prev_q;
  logic [2:0]         ctl_ev;
  logic               pause_ev;
  logic               resume_ev;
  logic               step_ev;
  logic [LW-1:0]      enc_lvl;
  logic [LW-1:0]      lvl_q, lvl_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               nf_q;
  logic               adv;
  state_e             state_q, state_d;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign ctl_ev    = synced[NUM_SPEEDS +: 3] & ~ctl_prev_q;
  assign pause_ev  = ctl_ev[0];
  assign resume_ev = ctl_ev[1];
  assign step_ev   = ctl_ev[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ctl_prev_q <= '0;
    end else begin
      sync_q[0] <= {step, resume, pause, speed_req};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ctl_prev_q <= synced[NUM_SPEEDS +: 3];
    end
  end

  always_comb begin
    enc_lvl = LW'(1);
    for (int i = 0; i < NUM_SPEEDS; i++)
      if (synced[i]) enc_lvl = LW'(i + 1);
  end

  always_comb begin
    lvl_d  = lvl_q;
    step_d = step_q;
    if (frame_start) begin
      lvl_d  = enc_lvl;
      step_d = sat_step(enc_lvl);
    end
  end

  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    unique case (state_q)
      RUN: begin
        adv = frame_start;
        if (pause_ev) state_d = PAUSED;
      end
      PAUSED: begin
        if (pause_ev)       state_d = PAUSED;
        else if (resume_ev) state_d = RUN;
        else if (step_ev)   state_d = STEP_PEND;
      end
      STEP_PEND: begin
        // pause beats resume; the pending step is then dropped
        if (pause_ev && resume_ev) begin
          state_d = PAUSED;
        end else begin
          adv = frame_start;
          if (resume_ev)        state_d = RUN;
          else if (frame_start) state_d = PAUSED;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // phase uses the step latched by the same frame_start
  assign phase_d = adv ? phase_q + PHASE_W'(step_d) : phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lvl_q   <= LW'(1);
      step_q  <= sat_step(LW'(1));
      phase_q <= '0;
      nf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      nf_q    <= adv;
    end
  end

  assign next_frame  = nf_q;
  assign step_size   = step_q;
  assign speed_level = lvl_q;
  assign paused      = (state_q != RUN);
  assign phase       = phase_q;

endmodule
